// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: datapath width, PC step and the queued fetch entry.
package mips_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid queue between instruction memory and decode; flush wins over push.
module fetch_skid_fifo
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // Guard against overflow/underflow even though the issue rule already prevents them.
  assign push_ok = push & (count != 2'd2);
  assign pop_ok  = pop & (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Pointer, count and storage update; pointers wrap mod 2 by being 1 bit wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch: PC register, single in-flight read tracking, issue control and
// the decode-facing view of the skid queue head.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4
);
  logic [31:0]  pc;
  logic [31:0]  inflight_pc;
  logic         inflight;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         push;
  logic         issue;
  logic [2:0]   occ;
  logic [31:0]  head_pc4;
  logic [31:0]  last_pc;
  logic [31:0]  last_instr;
  logic [31:0]  last_pc4;

  assign id_valid = (count != 2'd0);
  assign pop      = id_valid & id_ready;
  // A response arriving during a redirect belongs to the abandoned path.
  assign push     = inflight & ~redirect_valid;

  // Slots already spoken for (queued + in flight); a pop this cycle frees one.
  assign occ   = {1'b0, count} + {2'b00, inflight};
  assign issue = ~rst & ~redirect_valid & (occ < (3'd2 + {2'b00, pop}));

  assign imem_en   = issue;
  assign imem_addr = pc[IMEM_AW+1:2];

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = imem_rdata;

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (push_entry),
    .head    (head),
    .count   (count)
  );

  // PC and in-flight tracking; redirect overrides issue and drops the pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + PC_STEP;
      end
    end
  end

  assign head_pc4 = head.pc + PC_STEP;

  // Remember the last presented head so outputs hold their value while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc    <= '0;
      last_instr <= '0;
      last_pc4   <= '0;
    end else if (id_valid) begin
      last_pc    <= head.pc;
      last_instr <= head.instr;
      last_pc4   <= head_pc4;
    end
  end

  assign id_pc    = id_valid ? head.pc    : last_pc;
  assign id_instr = id_valid ? head.instr : last_instr;
  assign id_pc4   = id_valid ? head_pc4   : last_pc4;
endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction-fetch stage of the MIPS core, upstream of decode. It owns the PC and issues word reads to the synchronous instruction memory, which returns data one cycle after the request. Returned instructions are buffered in a 2-entry queue and presented to decode over a valid/ready handshake. Taken branches and jumps resolved downstream redirect fetch through a single-cycle redirect input.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `IMEM_AW`, default 8: instruction-memory word-address width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_en`  out  1: read request this cycle.
- `imem_addr`  out  IMEM_AW: word address, equal to `pc[IMEM_AW+1:2]`.
- `imem_rdata`  in  32: instruction, valid the cycle after `imem_en`.
- `redirect_valid`  in  1: single-cycle pulse that loads the PC.
- `redirect_pc`  in  32: new PC. Bits [1:0] are ignored and treated as 00.
- `id_valid`  out  1: the `id_*` outputs hold an instruction.
- `id_ready`  in  1: decode accepts the instruction this cycle.
- `id_instr`  out  32: instruction word.
- `id_pc`  out  32: address of `id_instr`.
- `id_pc4`  out  32: `id_pc + 4`, mod 2^32.

## Operation
- **State.** `pc` (32 bits), `inflight` (1 bit) plus the PC of the in-flight read, and a 2-entry FIFO of {pc, instr} with `count` from 0 to 2.
- **Reset.** While `rst`=1, all state is reset on the clock edge:
  - `pc`=RESET_PC, `count`=0, `inflight`=0.
  - `imem_en`=0, `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pc4`=0.
- **Pop.** `pop` = `id_valid` & `id_ready`. The head entry leaves the FIFO.
- **Issue.** `imem_en` = !`rst` & !`redirect_valid` & (`count` + `inflight` − `pop` < 2).
  - On issue: `inflight`<=1, its PC is latched, and `pc`<=`pc`+4 (wraps mod 2^32).
- **Response.** When `inflight`=1, `imem_rdata` and the in-flight PC are pushed into the FIFO next edge. Space for the push is guaranteed by the issue rule.
- **Simultaneous events.** Push and pop in the same cycle leave `count` unchanged.
- **Redirect.** Redirect has priority over every other event.
  - `pc`<=`redirect_pc` & ~3, the FIFO is flushed (`count`<=0), the in-flight response is discarded, and no issue happens that cycle.
  - If `pop` coincides with `redirect_valid`, the handshake still completes (decode keeps that instruction), and the flush then applies.
- **Output stability.** `id_*` always reflect the FIFO head. While `id_valid`=1 and `id_ready`=0, they hold stable.
- **Empty FIFO.** When `count`=0, `id_valid`=0 and `id_instr`/`id_pc`/`id_pc4` keep their last values.
- **Reset mid-operation.** Asserting `rst` during a stall or an in-flight read drops everything. No instruction is emitted from the discarded state.

## Timing
- **Start-up.** Cycle 0 is the first cycle with `rst`=0. `imem_en`=1 with `imem_addr`=RESET_PC>>2 in cycle 0. Data returns in cycle 1, and `id_valid`=1 in cycle 2. Fetch-to-decode latency is 2 cycles.
- **Throughput.** With `id_ready` held at 1, one instruction per cycle from cycle 2 onward, with consecutive PCs.
- **Stall.** When `id_ready` drops, at most 2 more reads complete into the FIFO, then `imem_en`=0. When `id_ready` rises, the 2 buffered entries drain back-to-back with no bubble, and issue resumes in the same cycle as the first pop.
- **Redirect at cycle t.** `imem_en`=0 in t. The read of `redirect_pc` issues in t+1, and the first redirected instruction has `id_valid`=1 in t+3. `id_valid`=0 in t+1 and t+2.
- **Timing paths.** No combinational path from `imem_rdata` to `id_*`. `imem_en` depends combinationally on `id_ready` and `redirect_valid` only.

## Structure
- **Shared package `mips_pkg`.**
  - `XLEN`=32.
  - `PC_STEP`=4.
  - Default `RESET_PC`.
  - Typedef `fetch_entry_t` {pc[31:0], instr[31:0]}.
- **Sub-module `fetch_skid_fifo`.** A 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush and count. Pointer wrap is mod 2. Flush takes priority over push.
- `mips_fetch` contains the PC register, in-flight tracking, issue logic and the `pc4` adder.

## Test plan
1. **Reset and start-up.** Hold `rst` 3 cycles, then release with `id_ready`=1 and memory word n = 0x1000_0000+n → `id_valid` rises in cycle 2 with `id_instr`=0x1000_0000, `id_pc`=0, `id_pc4`=4. Then one instruction per cycle: pc 4, 8, 12.
2. **Stall.** Drop `id_ready` for 5 cycles mid-stream → `id_*` hold steady, `imem_en`=0 after 2 further reads, and no instruction is lost or duplicated after resume.
3. **Redirect while streaming.** Pulse `redirect_valid` with `redirect_pc`=0x40 → in-flight and queued instructions are discarded. `id_valid`=0 for 2 cycles, then `id_pc`=0x40, 0x44.
4. **Redirect during a full stall, coincident with pop.** FIFO full, `id_ready`=1 and redirect to 0x83 in the same cycle → the current head is consumed, the remainder is flushed, and the next `id_pc`=0x80.
5. **PC wrap.** Redirect to 0xFFFF_FFFC → `id_pc4`=0, and the next `id_pc`=0x0000_0000.
6. **Reset mid-operation.** Assert `rst` for 1 cycle while the FIFO is full → outputs return to reset values, and start-up repeats from RESET_PC as in scenario 1.
